// File: rtl/line_draw_pkg.sv
// Shared types and widths for the line-draw arbiter and its Bresenham stepper.
package line_draw_pkg;

    localparam int H_W     = 11;
    localparam int V_W     = 10;
    localparam int ERR_W   = 13;
    localparam int COLOR_W = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [H_W-1:0]     x1;
        logic [V_W-1:0]     y1;
        logic [H_W-1:0]     x2;
        logic [V_W-1:0]     y2;
        logic [COLOR_W-1:0] color;
    } seg_t;

    function automatic logic signed [ERR_W-1:0] abs_err(input logic signed [ERR_W-1:0] d);
        return (d < 0) ? -d : d;
    endfunction

endpackage

// File: rtl/line_stepper.sv
// Bresenham stepper: load computes deltas/direction/error, each step advances one pixel.
module line_stepper
    import line_draw_pkg::*;
(
    input  logic           clk_in,
    input  logic           rst_n_in,
    input  logic           load_in,
    input  logic           step_in,
    input  logic [H_W-1:0] x1_in,
    input  logic [V_W-1:0] y1_in,
    input  logic [H_W-1:0] x2_in,
    input  logic [V_W-1:0] y2_in,
    output logic [H_W-1:0] x_out,
    output logic [V_W-1:0] y_out,
    output logic           last_out
);

    logic [H_W-1:0]          x_q, x_d;
    logic [V_W-1:0]          y_q, y_d;
    logic signed [ERR_W-1:0] err_q, err_d;
    logic signed [ERR_W-1:0] dx_q, dx_d;
    logic signed [ERR_W-1:0] dy_q, dy_d;
    logic                    sx_neg_q, sx_neg_d;
    logic                    sy_neg_q, sy_neg_d;

    logic signed [ERR_W-1:0] diff_x, diff_y, abs_x, abs_y;
    logic signed [ERR_W:0]   e2;
    logic                    step_x, step_y;

    always_comb begin
        diff_x = $signed({2'b00, x2_in}) - $signed({2'b00, x1_in});
        diff_y = $signed({3'b000, y2_in}) - $signed({3'b000, y1_in});
        abs_x  = abs_err(diff_x);
        abs_y  = abs_err(diff_y);
        // Error doubled into one extra bit so the comparisons cannot overflow.
        e2     = $signed({err_q, 1'b0});
        step_x = e2 >= $signed({dy_q[ERR_W-1], dy_q});
        step_y = e2 <= $signed({dx_q[ERR_W-1], dx_q});

        x_d      = x_q;
        y_d      = y_q;
        err_d    = err_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;

        if (load_in) begin
            x_d      = x1_in;
            y_d      = y1_in;
            dx_d     = abs_x;
            dy_d     = -abs_y;
            err_d    = abs_x - abs_y;
            sx_neg_d = diff_x < 0;
            sy_neg_d = diff_y < 0;
        end else if (step_in) begin
            err_d = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
            if (step_x) x_d = sx_neg_q ? x_q - 1'b1 : x_q + 1'b1;
            if (step_y) y_d = sy_neg_q ? y_q - 1'b1 : y_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            x_q      <= '0;
            y_q      <= '0;
            err_q    <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            err_q    <= err_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
        end
    end

    assign x_out    = x_q;
    assign y_out    = y_q;
    assign last_out = (x_q == x2_in) && (y_q == y2_in);

endmodule

// File: rtl/line_draw_arbiter.sv
// Round-robin arbiter sharing one line stepper among NUM_REQ segment sources.
// Optional screen clipping is enabled with LINE_DRAW_ARBITER_CLIP_EN.
module line_draw_arbiter
    import line_draw_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned V_ACTIVE = 720,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic [NUM_REQ-1:0]         req_valid_in,
    output logic [NUM_REQ-1:0]         req_ready_out,
    input  logic [NUM_REQ*H_W-1:0]     req_x1_in,
    input  logic [NUM_REQ*H_W-1:0]     req_x2_in,
    input  logic [NUM_REQ*V_W-1:0]     req_y1_in,
    input  logic [NUM_REQ*V_W-1:0]     req_y2_in,
    input  logic [NUM_REQ*COLOR_W-1:0] req_color_in,
    output logic                       pix_valid_out,
    input  logic                       pix_ready_in,
    output logic [H_W-1:0]             pix_x_out,
    output logic [V_W-1:0]             pix_y_out,
    output logic [COLOR_W-1:0]         pix_color_out,
    output logic [ID_W-1:0]            pix_id_out,
    output logic                       pix_last_out,
    output logic                       done_out,
    output logic [ID_W-1:0]            done_id_out,
    output logic                       busy_out
);

    state_e          state_q, state_d;
    seg_t            seg_q, seg_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] ptr_q, ptr_d;

    logic [ID_W-1:0] cand, gnt_idx;
    logic            gnt_found;
    logic            load, step, last, visible, advance;

    // First valid requester after the pointer, wrapping around.
    always_comb begin
        cand      = '0;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!gnt_found && req_valid_in[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

`ifdef LINE_DRAW_ARBITER_CLIP_EN
    assign visible = (32'(pix_x_out) < H_ACTIVE) && (32'(pix_y_out) < V_ACTIVE);
`else
    logic unused_clip;
    assign unused_clip = ^{H_ACTIVE, V_ACTIVE};
    assign visible     = 1'b1;
`endif

    // Hidden pixels step without waiting for the framebuffer.
    assign advance = (state_q == DRAW) && (!visible || pix_ready_in);

    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    seg_d.x1    = req_x1_in[H_W*gnt_idx +: H_W];
                    seg_d.y1    = req_y1_in[V_W*gnt_idx +: V_W];
                    seg_d.x2    = req_x2_in[H_W*gnt_idx +: H_W];
                    seg_d.y2    = req_y2_in[V_W*gnt_idx +: V_W];
                    seg_d.color = req_color_in[COLOR_W*gnt_idx +: COLOR_W];
                    id_d        = gnt_idx;
                    ptr_d       = gnt_idx;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                load    = 1'b1;
                state_d = DRAW;
            end
            DRAW: begin
                if (advance) begin
                    if (last) state_d = DONE;
                    else      step    = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            seg_q   <= '0;
            id_q    <= '0;
            ptr_q   <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    line_stepper u_stepper (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .load_in  (load),
        .step_in  (step),
        .x1_in    (seg_q.x1),
        .y1_in    (seg_q.y1),
        .x2_in    (seg_q.x2),
        .y2_in    (seg_q.y2),
        .x_out    (pix_x_out),
        .y_out    (pix_y_out),
        .last_out (last)
    );

    assign req_ready_out = (state_q == IDLE && gnt_found) ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign pix_valid_out = (state_q == DRAW) && visible;
    assign pix_last_out  = (state_q == DRAW) && visible && last;
    assign pix_color_out = seg_q.color;
    assign pix_id_out    = id_q;
    assign done_out      = (state_q == DONE);
    assign done_id_out   = id_q;
    assign busy_out      = (state_q != IDLE);

endmodule

// File: tb/tb_line_draw_arbiter.sv
// Directed self-checking bench for line_draw_arbiter.
module tb_line_draw_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*11-1:0] req_x1, req_x2;
    logic [N*10-1:0] req_y1, req_y2;
    logic [N*24-1:0] req_color;
    logic           pix_valid, pix_ready, pix_last, done;
    logic [10:0]    pix_x;
    logic [9:0]     pix_y;
    logic [23:0]    pix_color;
    logic [1:0]     pix_id, done_id_o;
    logic           busy;

    always #5 clk = ~clk;

    line_draw_arbiter #(.NUM_REQ(N), .H_ACTIVE(1280), .V_ACTIVE(720)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .req_valid_in  (req_valid),
        .req_ready_out (req_ready),
        .req_x1_in     (req_x1),
        .req_x2_in     (req_x2),
        .req_y1_in     (req_y1),
        .req_y2_in     (req_y2),
        .req_color_in  (req_color),
        .pix_valid_out (pix_valid),
        .pix_ready_in  (pix_ready),
        .pix_x_out     (pix_x),
        .pix_y_out     (pix_y),
        .pix_color_out (pix_color),
        .pix_id_out    (pix_id),
        .pix_last_out  (pix_last),
        .done_out      (done),
        .done_id_out   (done_id_o),
        .busy_out      (busy)
    );

    int checks = 0;
    int failures = 0;

    // Observations from the most recent capture() run.
    int hs_cyc, hs_id, first_cyc, done_cyc, done_id, np, stall_viol, onehot_viol;
    int cx[64], cy[64], cid[64], ccyc[64], ccol[64];
    bit cl[64];

    task automatic set_seg(input int r, input int x1, input int y1, input int x2, input int y2,
                           input int col);
        req_x1[11*r +: 11]    = 11'(x1);
        req_y1[10*r +: 10]    = 10'(y1);
        req_x2[11*r +: 11]    = 11'(x2);
        req_y2[10*r +: 10]    = 10'(y2);
        req_color[24*r +: 24] = 24'(col);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        pix_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs until done_out or the cycle budget; drops valid (and optionally scrambles the
    // requester's inputs) right after its handshake.
    task automatic capture(input int max_cyc, input bit rnd, input bit scr);
        logic [N-1:0] drop;
        logic [48:0]  hold_v, cur_v;
        bit           held;
        hs_cyc = -1; hs_id = -1; first_cyc = -1; done_cyc = -1; done_id = -1;
        np = 0; stall_viol = 0; onehot_viol = 0; held = 0; hold_v = '0; drop = '0;
        for (int i = 0; i < 64; i++) begin
            cx[i] = -1; cy[i] = -1; cid[i] = -1; ccyc[i] = -1; ccol[i] = -1; cl[i] = 0;
        end
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            cur_v = {pix_valid, pix_x, pix_y, pix_color, pix_id, pix_last};
            if (!$onehot0(req_ready)) onehot_viol++;
            if (held && cur_v !== hold_v) stall_viol++;
            held   = pix_valid && !pix_ready;
            hold_v = cur_v;
            if (req_ready != '0 && hs_cyc < 0) begin
                hs_cyc = c;
                for (int k = 0; k < N; k++) if (req_ready[k]) hs_id = k;
                drop = req_ready;
            end
            if (pix_valid && first_cyc < 0) first_cyc = c;
            if (pix_valid && pix_ready && np < 64) begin
                cx[np] = pix_x; cy[np] = pix_y; cl[np] = pix_last; cid[np] = pix_id;
                ccyc[np] = c; ccol[np] = pix_color;
                np++;
            end
            if (done) begin
                done_cyc = c;
                done_id  = done_id_o;
                break;
            end
            @(posedge clk);
            #1;
            if (drop != '0) begin
                req_valid = req_valid & ~drop;
                if (scr) set_seg(hs_id, $urandom_range(0, 2047), $urandom_range(0, 1023),
                                 $urandom_range(0, 2047), $urandom_range(0, 1023), $urandom);
                drop = '0;
            end
            if (rnd) pix_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; pix_ready = 1'b0;
        #1;
        checks++;
        if ({req_ready, pix_valid, pix_x, pix_y, pix_color, pix_id, pix_last, done, done_id_o, busy}
            !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got nonzero outputs, busy=%0b valid=%0b", busy, pix_valid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req_ready !== '0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: busy=%0b ready=%b done=%0b required 0", busy,
                     req_ready, done);
        end
    endtask

    task automatic test_basic();
        int ex[5] = '{0, 1, 2, 3, 4};
        int ey[5] = '{0, 1, 1, 2, 2};
        @(posedge clk); #1;
        set_seg(0, 0, 0, 4, 2, 'h123456);
        pix_ready = 1'b1;
        req_valid = 4'b0001;
        capture(40, 0, 1);
        checks++;
        if (hs_id !== 0) begin failures++; $display("FAIL basic_grant: got %0d required 0", hs_id); end
        checks++;
        if (first_cyc !== hs_cyc + 2) begin
            failures++;
            $display("FAIL basic_latency: first pixel cycle %0d required %0d", first_cyc, hs_cyc + 2);
        end
        checks++;
        if (np !== 5) begin failures++; $display("FAIL basic_count: got %0d required 5", np); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cx[i] !== ex[i] || cy[i] !== ey[i] || cl[i] !== (i == 4) || cid[i] !== 0 ||
                ccol[i] !== 'h123456) begin
                failures++;
                $display("FAIL basic_pixel%0d: got (%0d,%0d) last=%0b id=%0d col=%h required (%0d,%0d) last=%0b id=0 col=123456",
                         i, cx[i], cy[i], cl[i], cid[i], ccol[i], ex[i], ey[i], i == 4);
            end
        end
        checks++;
        if (done_cyc !== ccyc[4] + 1 || done_id !== 0) begin
            failures++;
            $display("FAIL basic_done: cycle %0d id %0d required cycle %0d id 0", done_cyc, done_id,
                     ccyc[4] + 1);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse: done=%0b busy=%0b required 0 0", done, busy);
        end
    endtask

    task automatic test_octant();
        int ex[5] = '{10, 9, 9, 8, 8};
        int ey[5] = '{10, 11, 12, 13, 14};
        @(posedge clk); #1;
        set_seg(3, 10, 10, 8, 14, 'hABCDEF);
        pix_ready = 1'b1;
        req_valid = 4'b1000;
        capture(40, 0, 1);
        checks++;
        if (np !== 5 || hs_id !== 3) begin
            failures++;
            $display("FAIL octant_count: got %0d pixels grant %0d required 5 grant 3", np, hs_id);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cx[i] !== ex[i] || cy[i] !== ey[i] || cid[i] !== 3 || cl[i] !== (i == 4)) begin
                failures++;
                $display("FAIL octant_pixel%0d: got (%0d,%0d) id=%0d last=%0b required (%0d,%0d) id=3 last=%0b",
                         i, cx[i], cy[i], cid[i], cl[i], ex[i], ey[i], i == 4);
            end
        end
        checks++;
        if (done_id !== 3) begin failures++; $display("FAIL octant_done_id: got %0d required 3", done_id); end
        @(negedge clk);
    endtask

    task automatic test_degenerate();
        @(posedge clk); #1;
        set_seg(2, 5, 7, 5, 7, 'h00FF00);
        pix_ready = 1'b1;
        req_valid = 4'b0100;
        capture(20, 0, 0);
        checks++;
        if (np !== 1 || cx[0] !== 5 || cy[0] !== 7 || cl[0] !== 1'b1 || done_id !== 2) begin
            failures++;
            $display("FAIL degenerate: got %0d pixels (%0d,%0d) last=%0b done_id=%0d required 1 (5,7) last=1 done_id=2",
                     np, cx[0], cy[0], cl[0], done_id);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int bad = 0;
        @(posedge clk); #1;
        set_seg(0, 0, 0, 6, 0, 'h0A0B0C);
        pix_ready = 1'b0;
        req_valid = 4'b0001;
        capture(300, 1, 0);
        checks++;
        if (np !== 7) begin failures++; $display("FAIL bp_count: got %0d required 7", np); end
        for (int i = 0; i < 7; i++)
            if (cx[i] !== i || cy[i] !== 0 || cl[i] !== (i == 6)) bad++;
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL bp_order: %0d bad pixels required 0", bad); end
        checks++;
        if (stall_viol !== 0) begin
            failures++;
            $display("FAIL bp_stable: %0d output changes during stall required 0", stall_viol);
        end
        checks++;
        if (done_cyc < 0) begin failures++; $display("FAIL bp_done: no done_out within budget"); end
        pix_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_arbitration();
        int got[8];
        int exp_g[8] = '{0, 2, 0, 2, 0, 1, 2, 0};
        int ng = 0;
        int viol = 0;
        do_reset();
        for (int r = 0; r < N; r++) set_seg(r, r, r, r, r, r);
        @(posedge clk); #1;
        pix_ready = 1'b1;
        req_valid = 4'b0101;
        for (int c = 0; c < 200 && ng < 8; c++) begin
            @(negedge clk);
            if (!$onehot0(req_ready)) viol++;
            if (req_ready != '0) begin
                for (int k = 0; k < N; k++) if (req_ready[k]) got[ng] = k;
                ng++;
            end
            @(posedge clk); #1;
            if (ng == 4) req_valid[1] = 1'b1;
        end
        req_valid = '0;
        repeat (6) @(posedge clk);
        checks++;
        if (ng !== 8) begin failures++; $display("FAIL arb_count: got %0d grants required 8", ng); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i < ng && got[i] !== exp_g[i]) begin
                failures++;
                $display("FAIL arb_grant%0d: got %0d required %0d", i, got[i], exp_g[i]);
            end
        end
        checks++;
        if (viol !== 0) begin failures++; $display("FAIL arb_onehot: %0d violations required 0", viol); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        bit found = 0;
        int dones = 0;
        @(posedge clk); #1;
        set_seg(0, 0, 0, 20, 20, 'h777777);
        pix_ready = 1'b1;
        req_valid = 4'b0001;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (pix_valid && pix_x == 11'd2) begin found = 1; break; end
            @(posedge clk); #1;
            if (busy) req_valid = '0;
        end
        checks++;
        if (!found) begin failures++; $display("FAIL abort_third_pixel: never reached x=2"); end
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        checks++;
        if ({req_ready, pix_valid, pix_x, pix_y, pix_color, pix_id, pix_last, done, done_id_o, busy}
            !== '0) begin
            failures++;
            $display("FAIL abort_outputs: got busy=%0b valid=%0b x=%0d required all 0", busy, pix_valid,
                     pix_x);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (dones !== 0) begin failures++; $display("FAIL abort_no_done: got %0d pulses required 0", dones); end
        // Requester 0 was granted last; a reset pointer must favour it again over 1.
        @(posedge clk); #1;
        set_seg(0, 3, 3, 3, 3, 1);
        set_seg(1, 4, 4, 4, 4, 2);
        req_valid = 4'b0011;
        capture(20, 0, 0);
        checks++;
        if (hs_id !== 0 || hs_cyc !== 0) begin
            failures++;
            $display("FAIL abort_ptr_reset: grant %0d at cycle %0d required 0 at 0", hs_id, hs_cyc);
        end
        @(posedge clk); #1;
        capture(20, 0, 0);
        checks++;
        if (hs_id !== 1 || cx[0] !== 4 || done_id !== 1) begin
            failures++;
            $display("FAIL abort_req1: grant %0d x %0d done_id %0d required 1 4 1", hs_id, cx[0], done_id);
        end
        @(negedge clk);
    endtask

`ifdef LINE_DRAW_ARBITER_CLIP_EN
    task automatic test_clip();
        int lasts = 0;
        @(posedge clk); #1;
        set_seg(0, 1278, 5, 1282, 5, 'h112233);
        pix_ready = 1'b1;
        req_valid = 4'b0001;
        capture(40, 0, 0);
        for (int i = 0; i < np; i++) if (cl[i]) lasts++;
        checks++;
        if (np !== 2 || cx[0] !== 1278 || cx[1] !== 1279) begin
            failures++;
            $display("FAIL clip_pixels: got %0d pixels x0=%0d x1=%0d required 2 1278 1279", np, cx[0],
                     cx[1]);
        end
        checks++;
        if (lasts !== 0 || done_cyc < 0) begin
            failures++;
            $display("FAIL clip_done: lasts=%0d done_cyc=%0d required 0 and a done pulse", lasts,
                     done_cyc);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        req_valid = '0;
        pix_ready = 1'b0;
        req_x1 = '0; req_x2 = '0; req_y1 = '0; req_y2 = '0; req_color = '0;
        rst_n = 1'b1;
        test_reset();
        test_basic();
        test_octant();
        test_degenerate();
        test_backpressure();
        test_arbitration();
        test_abort();
`ifdef LINE_DRAW_ARBITER_CLIP_EN
        test_clip();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
